// File: rtl/mudv_ctrl_if.sv
// mudv_ctrl_if: E-stage <-> multiply/divide unit bundle.
//   master (E-stage issue side): drives start/op/a/b, observes the rest.
//   slave  (mudv_ctrl)         : observes start/op/a/b, drives the rest.
//   start     valid, unflushed MUDV instruction in E this cycle
//   op        4-bit MUDV opcode
//   a, b      forwarded rs/rt operands
//   occupied  stall request toward the D-stage controller (combinational)
//   busy      multi-cycle op in flight (registered)
//   hi, lo    architectural HI/LO
//   rdata     MFHI/MFLO read data (combinational)
interface mudv_ctrl_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        occupied;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport master (
    output start, op, a, b,
    input  occupied, busy, hi, lo, rdata
  );

  modport slave (
    input  start, op, a, b,
    output occupied, busy, hi, lo, rdata
  );
endinterface

// File: rtl/mudv_ctrl.sv
// mudv_ctrl: E-stage multiply/divide sequencer. Owns HI/LO, runs fixed-latency
// mult/div ops one at a time, serves MTHI/MTLO/MFHI/MFLO.
// Ports:
//   clk    clock, all state changes on posedge
//   reset  synchronous active-high reset (aborts any op in flight, clears HI/LO)
//   bus    mudv_ctrl_if.slave: start/op/a/b in; occupied/busy/hi/lo/rdata out
// Parameters:
//   MUL_CYC  busy cycles for MULT/MULTU (and MADD-class), 1..15
//   DIV_CYC  busy cycles for DIV/DIVU, 1..15
// Optional feature macro: MUDV_MADD_EN enables ops 9-12 (MADD/MADDU/MSUB/MSUBU);
// without it those opcodes behave as NOP.
module mudv_ctrl #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic      clk,
  input  logic      reset,
  mudv_ctrl_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MUDV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  logic        is_long;
  logic        is_div;
  logic [63:0] res;

  function automatic logic signed [63:0] mul_s(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] xs;
    logic signed [63:0] ys;
    xs = $signed({{32{x[31]}}, x});
    ys = $signed({{32{y[31]}}, y});
    return xs * ys;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of overflowing.
  function automatic logic [63:0] div_s(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] nm, dm, qm, rm;
    nm = n[31] ? (~n + 32'd1) : n;
    dm = d[31] ? (~d + 32'd1) : d;
    qm = nm / dm;
    rm = nm % dm;
    if (n[31] ^ d[31]) qm = ~qm + 32'd1;
    if (n[31])         rm = ~rm + 32'd1;
    return {rm, qm};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] n, input logic [31:0] d);
    return {n % d, n / d};
  endfunction

  always_comb begin
    is_long = 1'b0;
    is_div  = 1'b0;
    case (bus.op)
      OP_MULT, OP_MULTU: is_long = 1'b1;
      OP_DIV, OP_DIVU: begin
        is_long = 1'b1;
        is_div  = 1'b1;
      end
`ifdef MUDV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_long = 1'b1;
`endif
      default: ;
    endcase
  end

  // 64-bit result latched at issue. HI/LO cannot change while busy, so the
  // accumulate forms may read them now rather than at commit.
  always_comb begin
    res = {hi_q, lo_q};
    case (bus.op)
      OP_MULT:  res = mul_s(bus.a, bus.b);
      OP_MULTU: res = mul_u(bus.a, bus.b);
      OP_DIV:   if (bus.b != 32'd0) res = div_s(bus.a, bus.b);
      OP_DIVU:  if (bus.b != 32'd0) res = div_u(bus.a, bus.b);
`ifdef MUDV_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + mul_s(bus.a, bus.b);
      OP_MADDU: res = {hi_q, lo_q} + mul_u(bus.a, bus.b);
      OP_MSUB:  res = {hi_q, lo_q} - mul_s(bus.a, bus.b);
      OP_MSUBU: res = {hi_q, lo_q} - mul_u(bus.a, bus.b);
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_long) begin
            pend_hi_d = res[63:32];
            pend_lo_d = res[31:0];
            cnt_d     = is_div ? 4'(DIV_CYC) : 4'(MUL_CYC);
            state_d   = BUSY;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      BUSY: begin
        // Any start seen here is a stall violation and is dropped.
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign bus.busy     = (state_q == BUSY);
  assign bus.occupied = (bus.start & is_long) | bus.busy;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.rdata    = (bus.op == OP_MFHI) ? hi_q :
                        (bus.op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mudv_ctrl.sv
// tb_mudv_ctrl: directed bench for mudv_ctrl. Multi-cycle ops push their
// expected HI/LO and busy length into a queue at issue; the entry is popped and
// compared once busy drops.
module tb_mudv_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mudv_ctrl_if mif ();

  mudv_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.tag = tag; e.hi = h; e.lo = l; e.cyc = c;
    sb.push_back(e);
  endtask

  // Drive one start for a full cycle; occupied/rdata checked before the edge.
  task automatic issue(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic exp_occ, input logic [31:0] exp_rd);
    @(negedge clk);
    mif.start = 1'b1; mif.op = o; mif.a = x; mif.b = y;
    #1;
    chk({tag, ".occupied"}, 32'(mif.occupied), 32'(exp_occ));
    chk({tag, ".rdata"}, mif.rdata, exp_rd);
    @(posedge clk);
    #1;
    mif.start = 1'b0; mif.op = 4'd0; mif.a = 32'd0; mif.b = 32'd0;
  endtask

  task automatic wait_commit();
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      chk("scoreboard.empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (!mif.busy) break;
      n++;
    end
    chk({e.tag, ".busy_cycles"}, 32'(n), 32'(e.cyc));
    chk({e.tag, ".hi"}, mif.hi, e.hi);
    chk({e.tag, ".lo"}, mif.lo, e.lo);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [63:0] up;
    longint      sp;
    bit          late;

    mif.start = 1'b0; mif.op = 4'd0; mif.a = 32'd0; mif.b = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset.busy", 32'(mif.busy), 32'd0);
    chk("reset.occupied", 32'(mif.occupied), 32'd0);
    chk("reset.hi", mif.hi, 32'd0);
    chk("reset.lo", mif.lo, 32'd0);

    // MTHI then MFHI
    issue("mthi", 4'd5, 32'h12345678, 32'd0, 1'b0, 32'd0);
    chk("mthi.busy", 32'(mif.busy), 32'd0);
    issue("mfhi", 4'd7, 32'd0, 32'd0, 1'b0, 32'h12345678);
    chk("mfhi.busy", 32'(mif.busy), 32'd0);
    chk("mfhi.lo", mif.lo, 32'd0);

    // MULT / MULTU
    push("mult", 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    issue("mult", 4'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 32'd0);
    wait_commit();
    push("multu", 32'h00000001, 32'hFFFFFFFE, 5);
    issue("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 1'b1, 32'd0);
    wait_commit();
    issue("mflo", 4'd8, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFE);

    // DIV / DIVU by zero / signed overflow
    push("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue("div", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 32'd0);
    wait_commit();
    push("divu0", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue("divu0", 4'd4, 32'd7, 32'd0, 1'b1, 32'd0);
    wait_commit();
    push("divovf", 32'h00000000, 32'h80000000, 10);
    issue("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0);
    wait_commit();
    push("divu", 32'd2, 32'd14, 10);
    issue("divu", 4'd4, 32'd100, 32'd7, 1'b1, 32'd0);
    wait_commit();

    // random operands against 64-bit bench arithmetic
    for (int i = 0; i < 3; i++) begin
      x = $urandom; y = $urandom;
      up = {32'd0, x} * {32'd0, y};
      push("rmultu", up[63:32], up[31:0], 5);
      issue("rmultu", 4'd2, x, y, 1'b1, 32'd0);
      wait_commit();
      sp = longint'($signed(x)) * longint'($signed(y));
      push("rmult", sp[63:32], sp[31:0], 5);
      issue("rmult", 4'd1, x, y, 1'b1, 32'd0);
      wait_commit();
    end

    // MTLO during busy is dropped
    push("mult_mtlo", 32'd0, 32'd12, 4);
    issue("mult_mtlo", 4'd1, 32'd3, 32'd4, 1'b1, 32'd0);
    @(negedge clk);
    mif.start = 1'b1; mif.op = 4'd6; mif.a = 32'h0000DEAD;
    #1;
    chk("mtlo_busy.busy", 32'(mif.busy), 32'd1);
    chk("mtlo_busy.occupied", 32'(mif.occupied), 32'd1);
    @(posedge clk);
    #1 mif.start = 1'b0; mif.op = 4'd0; mif.a = 32'd0;
    wait_commit();

    // reserved opcode 13 ignored
    issue("op13", 4'd13, 32'h55555555, 32'd1, 1'b0, 32'd0);
    chk("op13.busy", 32'(mif.busy), 32'd0);
    chk("op13.lo", mif.lo, 32'd12);

    // reset during busy cycle 3 of a DIV
    issue("mthi_pre", 4'd5, 32'hCAFEF00D, 32'd0, 1'b0, 32'd0);
    issue("div_rst", 4'd3, 32'd100, 32'd3, 1'b1, 32'd0);
    repeat (3) @(negedge clk);
    chk("div_rst.busy_c3", 32'(mif.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("div_rst.busy", 32'(mif.busy), 32'd0);
    chk("div_rst.hi", mif.hi, 32'd0);
    chk("div_rst.lo", mif.lo, 32'd0);
    late = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (mif.busy || mif.hi != 32'd0 || mif.lo != 32'd0) late = 1'b1;
    end
    chk("div_rst.no_late_commit", 32'(late), 32'd0);

`ifdef MUDV_MADD_EN
    issue("mtlo1", 4'd6, 32'd1, 32'd0, 1'b0, 32'd0);
    push("maddu", 32'hFFFFFFFE, 32'h00000002, 5);
    issue("maddu", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd0);
    wait_commit();
    issue("mthi0", 4'd5, 32'd0, 32'd0, 1'b0, 32'd0);
    issue("mtlo0", 4'd6, 32'd0, 32'd0, 1'b0, 32'd0);
    sp = 64'sd0 - 64'sd2;
    push("msub", sp[63:32], sp[31:0], 5);
    issue("msub", 4'd11, 32'd1, 32'd2, 1'b1, 32'd0);
    wait_commit();
`else
    issue("mthi_m", 4'd5, 32'h0000AAAA, 32'd0, 1'b0, 32'd0);
    issue("madd_off", 4'd9, 32'd3, 32'd4, 1'b0, 32'd0);
    @(negedge clk);
    chk("madd_off.busy", 32'(mif.busy), 32'd0);
    chk("madd_off.hi", mif.hi, 32'h0000AAAA);
    chk("madd_off.lo", mif.lo, 32'd0);
`endif

    chk("scoreboard.drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
